// File: rtl/mem_stage_sram_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl_pkg
// Description : Shared constants and types for the memory-access stage and its
//               16-bit external SRAM controller. It holds the default widths,
//               the data-segment base address, the per-phase wait count and the
//               controller state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_sram_ctrl_pkg;

    localparam int C_WORD_W      = 32;    // register / data word width
    localparam int C_SRAM_DATA_W = 16;    // external SRAM data width
    localparam int C_SRAM_ADDR_W = 18;    // external SRAM half-word address width
    localparam int C_DATA_BASE   = 1024;  // byte address mapped to SRAM word 0
    localparam int C_WAIT_CYCLES = 1;     // extra cycles each half-word phase is held
    localparam int C_REG_IDX_W   = 4;     // destination register index width

    // Controller states: one idle slot, two half-word phases, one result slot.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // Width of the phase counter that runs 0..wait_cycles. A zero wait still
    // needs a one-bit counter so the vector is never empty.
    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles <= 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage : mem_stage_sram_ctrl_pkg
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl_sram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl_sram_controller
// Description : Splits one 32-bit load or store into two half-word accesses on
//               a 16-bit asynchronous SRAM. Each phase is held for
//               WAIT_CYCLES+1 clocks. ready is low from the moment a request
//               appears until the DONE cycle, when the assembled load word is
//               valid.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               mem_r_en, mem_w_en  - load / store request (store wins)
//               wdata               - store data word
//               rdata               - {data_hi, data_lo} load result
//               ready               - 0 = freeze the pipeline
//               half                - half-word select for the address (1 in HI)
//               sram_dq             - bidirectional SRAM data
//               sram_we_n           - active-low SRAM write enable
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl_sram_controller
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int SRAM_DATA_W = C_SRAM_DATA_W,
    parameter int WAIT_CYCLES = C_WAIT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [2*SRAM_DATA_W-1:0] wdata,
    output logic [2*SRAM_DATA_W-1:0] rdata,
    output logic                     ready,
    output logic                     half,
    inout  wire  [SRAM_DATA_W-1:0]   sram_dq,
    output logic                     sram_we_n
);

    localparam int                CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    sram_state_e            r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SRAM_DATA_W-1:0] r_data_lo;
    logic [SRAM_DATA_W-1:0] r_data_hi;
    logic [SRAM_DATA_W-1:0] r_dq_out;
    logic                   r_we_n;

    logic w_req;
    logic w_load;
    logic w_phase_end;

    assign w_req       = mem_r_en | mem_w_en;
    // A request with both enables set is a store and must not disturb the
    // load result registers.
    assign w_load      = mem_r_en & ~mem_w_en;
    assign w_phase_end = (r_cnt == CNT_LAST);

    // Write enable and the driven data are registered together, so the bus is
    // driven exactly in the cycles where the SRAM sees we_n low and the
    // external device has its outputs off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_data_lo <= '0;
            r_data_hi <= '0;
            r_dq_out  <= '0;
            r_we_n    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state  <= ST_LO;
                        r_cnt    <= '0;
                        r_we_n   <= ~mem_w_en;
                        r_dq_out <= wdata[SRAM_DATA_W-1:0];
                    end
                end
                ST_LO: begin
                    if (w_phase_end) begin
                        // Sample at the end of the phase, after the full
                        // access time has elapsed.
                        if (w_load) begin
                            r_data_lo <= sram_dq;
                        end
                        r_state  <= ST_HI;
                        r_cnt    <= '0;
                        r_dq_out <= wdata[2*SRAM_DATA_W-1:SRAM_DATA_W];
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (w_phase_end) begin
                        if (w_load) begin
                            r_data_hi <= sram_dq;
                        end
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_we_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Upstream registers advance on this edge, so the next
                    // instruction is seen fresh in IDLE.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_we_n  <= 1'b1;
                end
            endcase
        end
    end

    // Non-memory instructions pass through IDLE without any stall.
    assign ready     = (r_state == ST_DONE) || ((r_state == ST_IDLE) && !w_req);
    assign half      = (r_state == ST_HI);
    assign rdata     = {r_data_hi, r_data_lo};
    assign sram_we_n = r_we_n;
    assign sram_dq   = r_we_n ? {SRAM_DATA_W{1'bz}} : r_dq_out;

endmodule : mem_stage_sram_ctrl_sram_controller
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl
// Description : Memory-access pipeline stage. Translates the ALU byte address
//               into an SRAM half-word address, runs loads/stores through the
//               SRAM controller, passes the EXE/MEM fields through to MEM/WB and
//               gates writeback with ready so stalls become bubbles.
// Ports       : clk, rst                - clock, asynchronous active-high reset
//               wb_en_in / wb_en_out    - writeback enable (out = in & ready)
//               mem_r_en_in / _out      - load request / passthrough
//               mem_w_en_in             - store request
//               alu_res_in / _out       - byte address or result / passthrough
//               val_r_m_in              - store data
//               dest_in / dest_out      - destination register / passthrough
//               mem_data_out            - load result
//               ready                   - 0 = freeze pipeline
//               sram_addr, sram_dq, sram_we_n - external SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int WORD_W      = C_WORD_W,
    parameter int SRAM_DATA_W = C_SRAM_DATA_W,
    parameter int SRAM_ADDR_W = C_SRAM_ADDR_W,
    parameter int DATA_BASE   = C_DATA_BASE,
    parameter int WAIT_CYCLES = C_WAIT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en_in,
    input  logic                   mem_r_en_in,
    input  logic                   mem_w_en_in,
    input  logic [WORD_W-1:0]      alu_res_in,
    input  logic [WORD_W-1:0]      val_r_m_in,
    input  logic [C_REG_IDX_W-1:0] dest_in,
    output logic                   wb_en_out,
    output logic                   mem_r_en_out,
    output logic [WORD_W-1:0]      alu_res_out,
    output logic [WORD_W-1:0]      mem_data_out,
    output logic [C_REG_IDX_W-1:0] dest_out,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    output logic                   sram_we_n
);

    // Only the low SRAM_ADDR_W+1 bits of (alu_res - DATA_BASE) reach the
    // address; subtraction modulo 2^n agrees with the full-width result in
    // those bits, so the upper address bits are simply not involved.
    localparam int OFF_W  = SRAM_ADDR_W + 1;
    localparam int WIDX_W = SRAM_ADDR_W - 1;

    logic [OFF_W-1:0]  w_offset;
    logic [WIDX_W-1:0] w_word_idx;
    logic              w_half;
    logic              w_ready;

    assign w_offset   = alu_res_in[OFF_W-1:0] - OFF_W'(DATA_BASE);
    assign w_word_idx = w_offset[OFF_W-1:2];
    assign sram_addr  = {w_word_idx, w_half};

    mem_stage_sram_ctrl_sram_controller #(
        .SRAM_DATA_W (SRAM_DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_sram_controller (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en_in),
        .mem_w_en  (mem_w_en_in),
        .wdata     (val_r_m_in),
        .rdata     (mem_data_out),
        .ready     (w_ready),
        .half      (w_half),
        .sram_dq   (sram_dq),
        .sram_we_n (sram_we_n)
    );

    // MEM/WB captures a bubble while stalled, never a half-finished load.
    assign wb_en_out    = wb_en_in & w_ready;
    assign ready        = w_ready;
    assign mem_r_en_out = mem_r_en_in;
    assign alu_res_out  = alu_res_in;
    assign dest_out     = dest_in;

endmodule : mem_stage_sram_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sram_ctrl
// Description : Self-checking bench for mem_stage_sram_ctrl. An SRAM device
//               model sits on the pins; a word-level reference memory predicts
//               load results and the expected pin activity per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

    localparam int WAIT_CYCLES = 1;
    localparam int PHASE_LEN   = WAIT_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en_in = 1'b0;
    logic        mem_r_en_in = 1'b0;
    logic        mem_w_en_in = 1'b0;
    logic [31:0] alu_res_in = '0;
    logic [31:0] val_r_m_in = '0;
    logic [3:0]  dest_in = '0;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_res_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dest_out;
    logic        ready;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Word-level reference: 17-bit word index -> 32-bit value.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] last_load = '0;

    // External SRAM device: outputs enabled whenever not being written.
    logic [15:0] sram_mem [0:262143];

    assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_dq;
        end
    end

    always #5 clk = ~clk;

    mem_stage_sram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .alu_res_in   (alu_res_in),
        .val_r_m_in   (val_r_m_in),
        .dest_in      (dest_in),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .mem_data_out (mem_data_out),
        .dest_out     (dest_out),
        .ready        (ready),
        .sram_addr    (sram_addr),
        .sram_dq      (sram_dq),
        .sram_we_n    (sram_we_n)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input int unsigned widx);
        return ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
    endfunction

    // One instruction presented to the stage; returns after its last cycle
    // (the DONE cycle for memory ops), so the next call advances on that edge.
    task automatic run_op(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] val,
                          input logic [3:0] dst);
        logic [31:0] offs;
        int unsigned widx;
        logic        hi;
        @(posedge clk);
        #1;
        wb_en_in    = wb;
        mem_r_en_in = rd;
        mem_w_en_in = wr;
        alu_res_in  = alu;
        val_r_m_in  = val;
        dest_in     = dst;
        if (!(rd || wr)) begin
            @(negedge clk);
            check_val("nm_ready",    ready,        1);
            check_val("nm_wb_en",    wb_en_out,    wb);
            check_val("nm_alu_res",  alu_res_out,  alu);
            check_val("nm_dest",     dest_out,     dst);
            check_val("nm_mem_r_en", mem_r_en_out, 0);
            check_val("nm_we_n",     sram_we_n,    1);
            return;
        end
        offs = alu - 32'd1024;
        widx = (offs >> 2) & 32'h1FFFF;
        // Request cycle: still idle, but already stalling.
        @(negedge clk);
        check_val("req_ready", ready,     0);
        check_val("req_wb_en", wb_en_out, 0);
        check_val("req_we_n",  sram_we_n, 1);
        for (int i = 0; i < 2 * PHASE_LEN; i++) begin
            @(negedge clk);
            hi = (i >= PHASE_LEN);
            check_val("ph_ready", ready,     0);
            check_val("ph_wb_en", wb_en_out, 0);
            check_val("ph_addr",  sram_addr, (widx << 1) | hi);
            check_val("ph_we_n",  sram_we_n, wr ? 0 : 1);
            if (wr) begin
                check_val("ph_dq", sram_dq, hi ? val[31:16] : val[15:0]);
            end
        end
        if (wr) begin
            ref_mem[widx] = val;
        end else begin
            last_load = ref_read(widx);
        end
        @(negedge clk);
        check_val("done_ready",    ready,        1);
        check_val("done_wb_en",    wb_en_out,    wb);
        check_val("done_data",     mem_data_out, last_load);
        check_val("done_alu_res",  alu_res_out,  alu);
        check_val("done_dest",     dest_out,     dst);
        check_val("done_mem_r_en", mem_r_en_out, rd);
        check_val("done_we_n",     sram_we_n,    1);
    endtask

    task automatic clear_inputs();
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = '0;
        val_r_m_in  = '0;
        dest_in     = '0;
    endtask

    initial begin
        logic [31:0] alu;
        logic [31:0] val;
        logic [3:0]  dst;
        int unsigned kind;
        int unsigned w;

        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = 16'h0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check_val("rst_we_n",  sram_we_n,    1);
        check_val("rst_data",  mem_data_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", ready, 1);

        // Directed: store, load back, address mapping, non-memory op.
        run_op(1, 0, 1, 32'd1024, 32'hDEADBEEF, 4'd3);
        run_op(1, 1, 0, 32'd1024, 32'h0,        4'd4);
        run_op(1, 1, 0, 32'd1028, 32'h0,        4'd1);
        run_op(0, 1, 0, 32'd1020, 32'h0,        4'd2);
        run_op(1, 0, 0, 32'd7,    32'h0,        4'd5);
        // Both enables set behaves as a store; then read it back.
        run_op(1, 1, 1, 32'd1028, 32'h12345678, 4'd6);
        // Back-to-back loads with distinct data.
        run_op(1, 1, 0, 32'd1024, 32'h0,        4'd7);
        run_op(1, 1, 0, 32'd1028, 32'h0,        4'd8);

        // Reset in the second HI cycle of a store.
        @(posedge clk);
        #1;
        wb_en_in    = 1'b1;
        mem_w_en_in = 1'b1;
        alu_res_in  = 32'd1024 + 32'd4000;
        val_r_m_in  = 32'hCAFEF00D;
        dest_in     = 4'd9;
        repeat (1 + PHASE_LEN + 1 - 1) @(posedge clk);
        @(posedge clk);
        #1;
        check_val("mid_hi_we_n", sram_we_n, 0);
        #1;
        rst = 1'b1;
        #1;
        check_val("arst_we_n",  sram_we_n,    1);
        check_val("arst_ready", ready,        0);
        check_val("arst_data",  mem_data_out, 0);
        clear_inputs();
        last_load = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("arst_rel_ready", ready,     1);
        check_val("arst_rel_we_n",  sram_we_n, 1);

        // Randomised mix of loads, stores, both-set and non-memory ops.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            w    = $urandom_range(0, 8);
            if (w == 8) begin
                alu = 32'd1020 + $urandom_range(0, 3);
            end else begin
                alu = 32'd1024 + 4 * w + $urandom_range(0, 3);
            end
            val = $urandom;
            dst = 4'($urandom_range(0, 15));
            case (kind)
                0:       run_op(1'($urandom_range(0, 1)), 0, 0, $urandom, val, dst);
                1:       run_op(1, 1, 0, alu, val, dst);
                2:       run_op(1, 0, 1, alu, val, dst);
                default: run_op(1, 1, 1, alu, val, dst);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_stage_sram_ctrl
`default_nettype wire
